// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (CPU/PPU) arbiter in front of a single external
// byte-wide memory. Each port has a one-deep pending slot; a three-state FSM
// grants one slot at a time, holds the access for WAIT_CYCLES cycles, then
// spends one recovery cycle pulsing the granted port's done.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 25
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_done,
    input  logic              ppu_req,
    input  logic [ADDR_W-1:0] ppu_addr,
    input  logic              ppu_wr,
    input  logic [7:0]        ppu_wdata,
    output logic [7:0]        ppu_rdata,
    output logic              ppu_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_oe,
    output logic              mem_we,
    output logic              cpu_overrun,
    output logic              ppu_overrun
);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [3:0]        cnt;
    logic              grant_cpu, grant_ppu;
    logic              last_cnt;

    // Pending slots
    logic              cpu_pend, ppu_pend;
    logic [ADDR_W-1:0] cpu_a, ppu_a;
    logic              cpu_w, ppu_w;
    logic [7:0]        cpu_d, ppu_d;

    // Granted access
    logic              g_ppu;
    logic [ADDR_W-1:0] g_addr;
    logic              g_wr;
    logic [7:0]        g_wdata;
    logic              last_ppu;

    assign last_cnt = (cnt == LAST_CNT);

    // Next-state and grant decision; round-robin on a tie
    always_comb begin
        state_nxt = state;
        grant_cpu = 1'b0;
        grant_ppu = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_pend && ppu_pend) begin
                    grant_cpu = last_ppu;
                    grant_ppu = ~last_ppu;
                end else begin
                    grant_cpu = cpu_pend;
                    grant_ppu = ppu_pend;
                end
                if (cpu_pend || ppu_pend)
                    state_nxt = ACCESS;
            end
            ACCESS:  if (last_cnt) state_nxt = RECOVER;
            RECOVER: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // External bus and done pulses, decoded from the current state
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_oe    = 1'b0;
        mem_we    = 1'b0;
        cpu_done  = 1'b0;
        ppu_done  = 1'b0;
        if (state == ACCESS) begin
            mem_addr  = g_addr;
            mem_wdata = g_wdata;
            mem_oe    = ~g_wr;
            mem_we    = g_wr;
        end
        if (state == RECOVER) begin
            cpu_done = ~g_ppu;
            ppu_done = g_ppu;
        end
    end

    // State register and wait counter
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_cpu || grant_ppu)
                cnt <= '0;
            else if (state == ACCESS && !last_cnt)
                cnt <= cnt + 4'd1;
        end
    end

    // Latch the granted slot's fields and remember who won
    always_ff @(posedge sysclk) begin
        if (reset) begin
            g_ppu    <= 1'b0;
            g_addr   <= '0;
            g_wr     <= 1'b0;
            g_wdata  <= '0;
            last_ppu <= 1'b0;
        end else if (grant_cpu) begin
            g_ppu    <= 1'b0;
            g_addr   <= cpu_a;
            g_wr     <= cpu_w;
            g_wdata  <= cpu_d;
            last_ppu <= 1'b0;
        end else if (grant_ppu) begin
            g_ppu    <= 1'b1;
            g_addr   <= ppu_a;
            g_wr     <= ppu_w;
            g_wdata  <= ppu_d;
            last_ppu <= 1'b1;
        end
    end

    // CPU pending slot; a req in the grant cycle refills the slot without overrun
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cpu_pend    <= 1'b0;
            cpu_a       <= '0;
            cpu_w       <= 1'b0;
            cpu_d       <= '0;
            cpu_overrun <= 1'b0;
        end else if (cpu_req) begin
            if (cpu_pend && !grant_cpu)
                cpu_overrun <= 1'b1;
            cpu_pend <= 1'b1;
            cpu_a    <= cpu_addr;
            cpu_w    <= cpu_wr;
            cpu_d    <= cpu_wdata;
        end else if (grant_cpu) begin
            cpu_pend <= 1'b0;
        end
    end

    // PPU pending slot, same rules as the CPU slot
    always_ff @(posedge sysclk) begin
        if (reset) begin
            ppu_pend    <= 1'b0;
            ppu_a       <= '0;
            ppu_w       <= 1'b0;
            ppu_d       <= '0;
            ppu_overrun <= 1'b0;
        end else if (ppu_req) begin
            if (ppu_pend && !grant_ppu)
                ppu_overrun <= 1'b1;
            ppu_pend <= 1'b1;
            ppu_a    <= ppu_addr;
            ppu_w    <= ppu_wr;
            ppu_d    <= ppu_wdata;
        end else if (grant_ppu) begin
            ppu_pend <= 1'b0;
        end
    end

    // Capture read data on the final access cycle of a read
    always_ff @(posedge sysclk) begin
        if (reset) begin
            cpu_rdata <= '0;
            ppu_rdata <= '0;
        end else if (state == ACCESS && last_cnt && !g_wr) begin
            if (g_ppu)
                ppu_rdata <= mem_rdata;
            else
                cpu_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized phase, every cycle
// compared against a timeline-based reference model of the arbiter.
module tb_mem_arbiter;

    localparam int unsigned W  = 2;
    localparam int unsigned AW = 25;

    logic          sysclk = 1'b0;
    logic          reset;
    logic          cpu_req, ppu_req, cpu_wr, ppu_wr;
    logic [AW-1:0] cpu_addr, ppu_addr, mem_addr;
    logic [7:0]    cpu_wdata, ppu_wdata, cpu_rdata, ppu_rdata;
    logic [7:0]    mem_wdata, mem_rdata;
    logic          cpu_done, ppu_done, mem_oe, mem_we;
    logic          cpu_overrun, ppu_overrun;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .sysclk(sysclk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
        .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_wr(ppu_wr),
        .ppu_wdata(ppu_wdata), .ppu_rdata(ppu_rdata), .ppu_done(ppu_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_oe(mem_oe), .mem_we(mem_we),
        .cpu_overrun(cpu_overrun), .ppu_overrun(ppu_overrun)
    );

    always #5 sysclk = ~sysclk;

    // Reference model: port 0 = CPU, 1 = PPU. An access granted in cycle g
    // occupies the bus in cycles g+1..g+W and signals done in cycle g+W+1.
    int            cyc;
    bit            pv[2];
    logic [AW-1:0] pa[2];
    bit            pw[2];
    logic [7:0]    pd[2];
    logic [7:0]    m_rd[2];
    bit            m_ovr[2];
    int            last_port;
    bit            busy;
    int            cur_port;
    logic [AW-1:0] cur_a;
    bit            cur_w;
    logic [7:0]    cur_d;
    int            acc_start;
    bit            exp_cdone, exp_pdone;
    int            done_log[$];

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            pv[p] = 0; pa[p] = '0; pw[p] = 0; pd[p] = '0;
            m_rd[p] = '0; m_ovr[p] = 0;
        end
        last_port = 0;
        busy      = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic grant(input int p);
        busy      = 1;
        cur_port  = p;
        cur_a     = pa[p];
        cur_w     = pw[p];
        cur_d     = pd[p];
        acc_start = cyc + 1;
        pv[p]     = 0;
        last_port = p;
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
            return;
        end
        if (busy && cyc == acc_start + int'(W) - 1 && !cur_w)
            m_rd[cur_port] = mem_rdata;
        if (busy && cyc == acc_start + int'(W))
            busy = 0;
        else if (!busy) begin
            if (pv[0] && pv[1]) grant(1 - last_port);
            else if (pv[0])     grant(0);
            else if (pv[1])     grant(1);
        end
        if (cpu_req) begin
            if (pv[0]) m_ovr[0] = 1;
            pv[0] = 1; pa[0] = cpu_addr; pw[0] = cpu_wr; pd[0] = cpu_wdata;
        end
        if (ppu_req) begin
            if (pv[1]) m_ovr[1] = 1;
            pv[1] = 1; pa[1] = ppu_addr; pw[1] = ppu_wr; pd[1] = ppu_wdata;
        end
    endtask

    // One clock: check outputs mid-cycle, apply the edge to the model, release pulses
    task automatic tick();
        bit act, dn;
        @(negedge sysclk);
        act = busy && cyc >= acc_start && cyc < acc_start + int'(W);
        dn  = busy && cyc == acc_start + int'(W);
        exp_cdone = dn && cur_port == 0;
        exp_pdone = dn && cur_port == 1;
        chk("mem_oe",    32'(mem_oe),    32'(act && !cur_w));
        chk("mem_we",    32'(mem_we),    32'(act && cur_w));
        chk("mem_addr",  32'(mem_addr),  act ? 32'(cur_a) : 32'd0);
        chk("mem_wdata", 32'(mem_wdata), act ? 32'(cur_d) : 32'd0);
        chk("cpu_done",  32'(cpu_done),  32'(exp_cdone));
        chk("ppu_done",  32'(ppu_done),  32'(exp_pdone));
        chk("cpu_rdata", 32'(cpu_rdata), 32'(m_rd[0]));
        chk("ppu_rdata", 32'(ppu_rdata), 32'(m_rd[1]));
        chk("cpu_ovr",   32'(cpu_overrun), 32'(m_ovr[0]));
        chk("ppu_ovr",   32'(ppu_overrun), 32'(m_ovr[1]));
        if (cpu_done) done_log.push_back(0);
        if (ppu_done) done_log.push_back(1);
        @(posedge sysclk);
        model_edge();
        cyc++;
        #1;
        cpu_req = 0;
        ppu_req = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        cpu_req = 0; ppu_req = 0; cpu_wr = 0; ppu_wr = 0;
        cpu_addr = '0; ppu_addr = '0; cpu_wdata = '0; ppu_wdata = '0;
        mem_rdata = '0;
        cyc = 0;
        model_reset();
        @(posedge sysclk);
        #1;
        do_reset();
        tick();

        // CPU read, no contention
        mem_rdata = 8'hA5;
        cpu_req = 1; cpu_addr = 25'h0008123; cpu_wr = 0;
        run(6);
        chk("read_rdata", 32'(cpu_rdata), 32'h0000_00A5);

        // PPU write leaves ppu_rdata alone
        ppu_req = 1; ppu_addr = 25'h0100400; ppu_wdata = 8'h3C; ppu_wr = 1;
        done_log.delete();
        run(6);
        chk("write_done_cnt", 32'(done_log.size()), 32'd1);
        chk("write_rdata", 32'(ppu_rdata), 32'd0);

        // Tie after reset: PPU first, CPU four cycles later
        do_reset();
        done_log.delete();
        cpu_req = 1; cpu_addr = 25'h0000011; cpu_wr = 0;
        ppu_req = 1; ppu_addr = 25'h0000022; ppu_wr = 0;
        mem_rdata = 8'h5A;
        run(10);
        chk("tie_count", 32'(done_log.size()), 32'd2);
        if (done_log.size() == 2) begin
            chk("tie_first", 32'(done_log[0]), 32'd1);
            chk("tie_second", 32'(done_log[1]), 32'd0);
        end

        // Round-robin: each port re-requests right after its done
        do_reset();
        done_log.delete();
        cpu_req = 1; ppu_req = 1;
        for (int i = 0; i < 26; i++) begin
            bit rc, rp;
            mem_rdata = 8'($urandom);
            tick();
            rc = exp_cdone; rp = exp_pdone;
            cpu_req = rc; ppu_req = rp;
            cpu_addr = 25'($urandom); ppu_addr = 25'($urandom);
        end
        cpu_req = 0; ppu_req = 0;
        run(6);
        chk("rr_count_ge6", 32'(done_log.size() >= 6), 32'd1);
        for (int i = 0; i < 6 && i < done_log.size(); i++)
            chk("rr_order", 32'(done_log[i]), 32'(i % 2 == 0 ? 1 : 0));

        // Overrun: CPU request replaced while queued behind a PPU access
        do_reset();
        ppu_req = 1; ppu_addr = 25'h0000777; ppu_wr = 0;
        tick();
        cpu_req = 1; cpu_addr = 25'h00000AA; cpu_wr = 0;
        tick();
        cpu_req = 1; cpu_addr = 25'h00000BB; cpu_wr = 0;
        run(10);
        chk("ovr_flag", 32'(cpu_overrun), 32'd1);
        chk("ovr_ppu_clear", 32'(ppu_overrun), 32'd0);

        // Reset on the second access cycle of a write aborts it
        do_reset();
        done_log.delete();
        cpu_req = 1; cpu_addr = 25'h0001234; cpu_wr = 1; cpu_wdata = 8'h99;
        run(3);
        reset = 1;
        tick();
        reset = 0;
        run(5);
        chk("abort_no_done", 32'(done_log.size()), 32'd0);
        cpu_req = 1; cpu_addr = 25'h0004321; cpu_wr = 0;
        mem_rdata = 8'h42;
        run(6);
        chk("after_abort_done", 32'(done_log.size()), 32'd1);
        chk("after_abort_rdata", 32'(cpu_rdata), 32'h42);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(99) == 0);
            cpu_req   = ($urandom_range(3) == 0);
            ppu_req   = ($urandom_range(3) == 0);
            cpu_addr  = 25'($urandom);
            ppu_addr  = 25'($urandom);
            cpu_wr    = 1'($urandom);
            ppu_wr    = 1'($urandom);
            cpu_wdata = 8'($urandom);
            ppu_wdata = 8'($urandom);
            mem_rdata = 8'($urandom);
            tick();
        end
        reset = 0;
        run(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of cycles an external access is held (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 25, meaning the width of the external address.
REQ-003 sysclk  in  1  the single system clock; all registers update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_req  in  1  one-cycle pulse requesting a CPU-side access, driven from the mapper's CPU side.
REQ-006 cpu_addr  in  ADDR_W  CPU access address (the mapper's ext_cpu_bus).
REQ-007 cpu_wr  in  1  1 = write, 0 = read; sampled with cpu_req.
REQ-008 cpu_wdata  in  8  CPU write data; sampled with cpu_req.
REQ-009 cpu_rdata  out  8  last completed CPU read data; held until the next CPU read completes.
REQ-010 cpu_done  out  1  one-cycle pulse when a CPU access completes.
REQ-011 ppu_req, ppu_addr, ppu_wr, ppu_wdata, ppu_rdata, ppu_done SHALL be identical in direction, width and meaning to the cpu_* ports, for the PPU side.
REQ-012 mem_addr  out  ADDR_W  external memory address.
REQ-013 mem_wdata  out  8  external write data.
REQ-014 mem_rdata  in  8  external read data, valid on the last ACCESS cycle.
REQ-015 mem_oe  out  1  external read enable.
REQ-016 mem_we  out  1  external write enable.
REQ-017 cpu_overrun, ppu_overrun  out  1 each  sticky flag: a request overwrote a still-pending request on that port.

Function
REQ-018 Each port SHALL have a one-deep pending slot: on that port's req, capture addr/wr/wdata and set pending.
REQ-019 A req arriving while the slot is pending and not yet granted SHALL overwrite the captured fields, keep pending set, and set that port's overrun flag.
REQ-020 A req arriving in the same cycle its port is granted SHALL leave the granted access using the old fields, and SHALL load the new fields as pending.
REQ-021 The FSM SHALL have three states: IDLE, ACCESS, RECOVER.
REQ-022 IDLE transitions: with no slot pending, stay in IDLE; with one slot pending, grant that port; with both pending, grant the port not granted last. In every grant case, go to ACCESS with wait counter = 0, and clear the granted slot's pending flag.
REQ-023 In ACCESS, mem_addr/mem_wdata SHALL carry the granted fields; mem_oe = ~wr and mem_we = wr for exactly WAIT_CYCLES consecutive cycles.
REQ-024 On the last ACCESS cycle (counter = WAIT_CYCLES-1), a read SHALL load mem_rdata into the granted port's rdata register; the FSM then goes to RECOVER.
REQ-025 RECOVER SHALL last one cycle, with mem_oe = mem_we = 0 and the granted port's done = 1; the FSM then goes to IDLE.
REQ-026 Latency: with req at cycle 0 and no contention, done is asserted at cycle WAIT_CYCLES+2; rdata is valid from that cycle.
REQ-027 Throughput: the minimum grant-to-grant spacing SHALL be WAIT_CYCLES+2 cycles.
REQ-028 A write SHALL not modify the granted port's rdata register.
REQ-029 mem_oe and mem_we SHALL never be asserted together, and SHALL be 0 outside ACCESS.
REQ-030 mem_addr and mem_wdata SHALL be 0 outside ACCESS.
REQ-031 The wait counter SHALL be 4 bits wide and SHALL never wrap within an access.

Reset
REQ-032 While reset is high at a clock edge, the block SHALL go to IDLE, clear both pending flags, clear the counter, and set last-grant = CPU (so PPU wins the first tie).
REQ-033 The same reset condition SHALL clear cpu_rdata, ppu_rdata, cpu_done, ppu_done, both overrun flags, mem_addr, mem_wdata, mem_oe and mem_we to 0.
REQ-034 Reset asserted mid-ACCESS SHALL abort the access: mem_we/mem_oe SHALL be 0 from the cycle after the reset edge, and no done pulse SHALL be issued.
REQ-035 Req pulses sampled while reset is high SHALL be ignored.

Verification
REQ-036 CPU read, WAIT_CYCLES=2: cpu_req at cycle 0, addr 25'h0008123, mem_rdata = 8'hA5 -> mem_oe = 1 on cycles 2-3 with mem_addr = 25'h0008123; cpu_done at cycle 4; cpu_rdata = 8'hA5.
REQ-037 PPU write: ppu_req with addr 25'h0100400, wdata 8'h3C -> mem_we = 1 for 2 cycles with that addr/data; ppu_done pulses once; ppu_rdata unchanged.
REQ-038 Tie after reset: cpu_req and ppu_req in the same cycle -> PPU is serviced first, then CPU; the second done arrives 4 cycles after the first.
REQ-039 Round-robin: both ports re-request on every done for 6 accesses -> grants strictly alternate PPU, CPU, PPU, ...
REQ-040 Overrun: cpu_req (addr A), then cpu_req (addr B) while the first is still pending behind a PPU access -> only addr B is accessed; cpu_overrun = 1 and stays 1.
REQ-041 Reset on the second ACCESS cycle of a write -> mem_we = 0 from the next cycle; no done pulse; all outputs 0; the next request completes normally.
